// File: rtl/sd_spi_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared types and defaults for the SPI-mode SD card link sequencer.
//   sd_state_e      : sequencer state (INIT, IDLE, SHIFT)
//   SD_SLOW_HALF    : default clk cycles per SCLK half-period, slow mode
//   SD_FAST_HALF    : default clk cycles per SCLK half-period, fast mode
//   SD_INIT_CLOCKS  : default number of full SCLK periods issued at power-up
//   sd_cnt_width()  : width needed for a 0..max(a,b)-1 counter
// -----------------------------------------------------------------------------
package sd_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } sd_state_e;

    localparam int SD_SLOW_HALF   = 125;  // 50 MHz -> 200 kHz
    localparam int SD_FAST_HALF   = 2;    // 50 MHz -> 12.5 MHz
    localparam int SD_INIT_CLOCKS = 80;   // card needs at least 74

    // Counter width for values 0..max(a,b)-1; never narrower than one bit.
    function automatic int sd_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sd_spi_sequencer_if.sv
// -----------------------------------------------------------------------------
// sd_spi_sequencer_if
// Byte handshake between the SD command/data FSM (master) and the SPI link
// sequencer (slave). Signal prefixes are from the sequencer's point of view.
//   i_tx_valid : byte transfer request
//   i_tx_data  : byte to send, MSB first
//   o_tx_ready : sequencer can accept a byte
//   o_rx_valid : one-cycle pulse, o_rx_data holds the received byte
//   o_rx_data  : byte received on MISO
// -----------------------------------------------------------------------------
interface sd_spi_sequencer_if;

    logic       i_tx_valid;
    logic [7:0] i_tx_data;
    logic       o_tx_ready;
    logic       o_rx_valid;
    logic [7:0] o_rx_data;

    modport master (
        output i_tx_valid,
        output i_tx_data,
        input  o_tx_ready,
        input  o_rx_valid,
        input  o_rx_data
    );

    modport slave (
        input  i_tx_valid,
        input  i_tx_data,
        output o_tx_ready,
        output o_rx_valid,
        output o_rx_data
    );

endinterface

// File: rtl/sd_spi_sequencer_clk_tick.sv
// -----------------------------------------------------------------------------
// sd_clk_tick
// Half-period tick generator for the SCLK. A counter runs 0..HALF-1 and o_tick
// is high while it equals HALF-1; HALF is SLOW_HALF or FAST_HALF by i_fast.
//   i_clk    : system clock
//   i_rst_n  : synchronous active-low reset
//   i_clear  : restart the half-period from zero
//   i_fast   : 1 selects FAST_HALF, 0 selects SLOW_HALF
//   o_tick   : one half-period has elapsed
// -----------------------------------------------------------------------------
module sd_clk_tick
    import sd_pkg::*;
#(
    parameter int SLOW_HALF = SD_SLOW_HALF,
    parameter int FAST_HALF = SD_FAST_HALF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_fast,
    output logic o_tick
);

    localparam int CW = sd_cnt_width(SLOW_HALF, FAST_HALF);
    localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_HALF - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last;

    // The mode only changes together with i_clear, so the counter never sits
    // above the terminal value of the newly selected rate.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        last   = i_fast ? FAST_LAST : SLOW_LAST;
        o_tick = (cnt_q == last);
        cnt_d  = cnt_q + 1'b1;
        if (i_clear || o_tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_spi_sequencer.sv
// -----------------------------------------------------------------------------
// sd_spi_sequencer
// SPI-mode SD card link sequencer. Runs the card power-up clocking at the slow
// rate, then performs byte-wide full-duplex SPI mode-0 transfers on request.
// The speed is latched only when a byte is accepted, so SCLK never glitches.
//
// Build option: define SD_SEQ_INIT_EN to include the power-up (INIT) phase.
// Without it the block leaves reset directly in IDLE and no INIT counter is
// built.
//
// Ports:
//   i_clk, i_rst_n : system clock, synchronous active-low reset
//   i_fast         : requested speed, sampled at byte accept
//   i_cs_req       : chip-select request, followed while IDLE
//   bus            : byte handshake (tx valid/data/ready, rx valid/data)
//   o_init_done    : power-up sequence complete
//   o_fast         : speed of the current or last transfer
//   o_sclk, o_mosi : SPI clock (idles low) and data to the card
//   i_miso         : SPI data from the card
//   o_cs_n         : card chip select, active low
// -----------------------------------------------------------------------------
module sd_spi_sequencer
    import sd_pkg::*;
#(
    parameter int SLOW_HALF   = SD_SLOW_HALF,
    parameter int FAST_HALF   = SD_FAST_HALF,
    parameter int INIT_CLOCKS = SD_INIT_CLOCKS
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_fast,
    input  logic                     i_cs_req,
    sd_spi_sequencer_if.slave        bus,
    output logic                     o_init_done,
    output logic                     o_fast,
    output logic                     o_sclk,
    output logic                     o_mosi,
    input  logic                     i_miso,
    output logic                     o_cs_n
);

    if (INIT_CLOCKS < 74) begin : g_bad_init_clocks
        $error("sd_spi_sequencer: INIT_CLOCKS must be at least 74");
    end

`ifdef SD_SEQ_INIT_EN
    localparam int INIT_TICKS = 2 * INIT_CLOCKS;
    localparam int IW         = $clog2(INIT_TICKS);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_TICKS - 1);
    localparam sd_state_e RESET_STATE = ST_INIT;

    logic [IW-1:0] init_cnt_q, init_cnt_d;
`else
    localparam sd_state_e RESET_STATE = ST_IDLE;
`endif

    sd_state_e  state_q, state_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [3:0] bit_tick_q, bit_tick_d;   // SHIFT ticks already taken, 0..15
    logic       tx_ready_q, tx_ready_d;
    logic       rx_valid_q, rx_valid_d;
    logic       init_done_q, init_done_d;
    logic       fast_q, fast_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       cs_n_q, cs_n_d;

    logic       tick;
    logic       tick_clear;
    logic       tick_fast;

    // Every state entry restarts the half-period so the first SCLK phase of
    // a transfer or of power-up is always a full half-period long.
    assign tick_clear = (state_d != state_q);
    // Power-up always runs slow, whatever was latched before.
    assign tick_fast  = fast_q && (state_q != ST_INIT);

    sd_clk_tick #(
        .SLOW_HALF (SLOW_HALF),
        .FAST_HALF (FAST_HALF)
    ) u_clk_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (tick_clear),
        .i_fast  (tick_fast),
        .o_tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        bit_tick_d  = bit_tick_q;
        tx_ready_d  = 1'b0;
        rx_valid_d  = 1'b0;
        // Set one cycle after the first IDLE cycle and held until reset.
        init_done_d = init_done_q || (state_q != ST_INIT);
        fast_d      = fast_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
`ifdef SD_SEQ_INIT_EN
        init_cnt_d  = init_cnt_q;
`endif

        case (state_q)
`ifdef SD_SEQ_INIT_EN
            ST_INIT: begin
                cs_n_d = 1'b1;
                mosi_d = 1'b1;
                if (tick) begin
                    if (init_cnt_q == INIT_LAST) begin
                        sclk_d     = 1'b0;
                        state_d    = ST_IDLE;
                        tx_ready_d = 1'b1;
                    end else begin
                        sclk_d     = ~sclk_q;
                        init_cnt_d = init_cnt_q + 1'b1;
                    end
                end
            end
`endif
            ST_IDLE: begin
                sclk_d     = 1'b0;
                mosi_d     = 1'b1;
                cs_n_d     = ~i_cs_req;
                tx_ready_d = 1'b1;
                if (bus.i_tx_valid && tx_ready_q) begin
                    tx_sh_d    = bus.i_tx_data;
                    fast_d     = i_fast;
                    mosi_d     = bus.i_tx_data[7];
                    bit_tick_d = '0;
                    state_d    = ST_SHIFT;
                    tx_ready_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                // Chip select is frozen: cs_n_d keeps its default.
                if (tick) begin
                    bit_tick_d = bit_tick_q + 4'd1;
                    if (!bit_tick_q[0]) begin
                        // Rising edge: the card's MISO bit is stable here.
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], i_miso};
                    end else if (bit_tick_q != 4'd15) begin
                        // Falling edge: present the next bit before the
                        // card samples on the following rising edge.
                        sclk_d  = 1'b0;
                        mosi_d  = tx_sh_q[6];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                    end else begin
                        sclk_d     = 1'b0;
                        mosi_d     = 1'b1;
                        state_d    = ST_IDLE;
                        tx_ready_d = 1'b1;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                    end
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: the shift and data registers are reset along with the
            // control state so o_rx_data and the pins are defined from reset.
            state_q     <= RESET_STATE;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            bit_tick_q  <= '0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            fast_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b1;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            bit_tick_q  <= bit_tick_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            init_done_q <= init_done_d;
            fast_q      <= fast_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
        end
    end

`ifdef SD_SEQ_INIT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end
`endif

    assign bus.o_tx_ready = tx_ready_q;
    assign bus.o_rx_valid = rx_valid_q;
    assign bus.o_rx_data  = rx_data_q;
    assign o_init_done    = init_done_q;
    assign o_fast         = fast_q;
    assign o_sclk         = sclk_q;
    assign o_mosi         = mosi_q;
    assign o_cs_n         = cs_n_q;

endmodule

// File: tb/tb_sd_spi_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sd_spi_sequencer
// Self-checking bench for sd_spi_sequencer with default parameters
// (SLOW_HALF=125, FAST_HALF=2, INIT_CLOCKS=80). Works with and without
// SD_SEQ_INIT_EN. A small card model returns a fixed MISO pattern MSB first,
// changing after each SCLK rising edge, and records MOSI at each rising edge.
// -----------------------------------------------------------------------------
module tb_sd_spi_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic fast;
    logic cs_req;
    logic miso;
    logic init_done;
    logic o_fast;
    logic sclk;
    logic mosi;
    logic cs_n;

    sd_spi_sequencer_if bus();

    sd_spi_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_fast      (fast),
        .i_cs_req    (cs_req),
        .bus         (bus),
        .o_init_done (init_done),
        .o_fast      (o_fast),
        .o_sclk      (sclk),
        .o_mosi      (mosi),
        .i_miso      (miso),
        .o_cs_n      (cs_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- card model ----------------
    int         cyc            = 0;
    int         rise_total     = 0;
    int         rise_base      = 0;
    int         first_rise_cyc = 0;
    int         last_rise_cyc  = 0;
    int         rel;
    logic [7:0] mosi_sh  = '0;
    logic [7:0] miso_pat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge sclk) begin
        if (rise_total == rise_base) first_rise_cyc <= cyc;
        last_rise_cyc <= cyc;
        mosi_sh       <= {mosi_sh[6:0], mosi};
        rise_total    <= rise_total + 1;
    end

    always_comb begin
        rel  = rise_total - rise_base;
        miso = 1'b1;
        if (rel >= 0 && rel < 8) miso = miso_pat[7 - rel];
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!bus.o_tx_ready && k < 25000) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", {31'd0, bus.o_tx_ready}, 32'd1);
    endtask

    // Called at a negedge with o_tx_ready high: the next posedge accepts.
    task automatic start_xfer(input logic f, input logic [7:0] tx, input logic [7:0] pat);
        fast           = f;
        bus.i_tx_data  = tx;
        bus.i_tx_valid = 1'b1;
        miso_pat       = pat;
        rise_base      = rise_total;
    endtask

    // Returns at the negedge of the o_rx_valid cycle; lat counts cycles from
    // the accept cycle (accept cycle = 0), -1 on timeout.
    task automatic wait_rx(input bit hold, input int flip_at, output int lat,
                           output logic f1, output logic r1);
        lat = -1;
        f1  = 1'bx;
        r1  = 1'bx;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                f1 = o_fast;
                r1 = bus.o_tx_ready;
                if (!hold) bus.i_tx_valid = 1'b0;
            end
            if (n == flip_at) begin
                fast   = 1'b1;
                cs_req = 1'b0;
            end
            if (bus.o_rx_valid) begin
                lat = n;
                break;
            end
        end
    endtask

`ifdef SD_SEQ_INIT_EN
    // Called at the negedge where reset is released.
    task automatic init_sequence(input string tag);
        int done_at  = -1;
        bit pins_bad = 1'b0;
        bit rdy_bad  = 1'b0;
        bit rx_seen  = 1'b0;
        rise_base = rise_total;
        for (int n = 1; n <= 21000; n++) begin
            @(negedge clk);
            if (init_done) begin
                done_at = n;
                break;
            end
            if (!cs_n || !mosi) pins_bad = 1'b1;
            if (bus.o_tx_ready && n < 20000) rdy_bad = 1'b1;
            if (bus.o_rx_valid) rx_seen = 1'b1;
        end
        check({tag, "_done_latency"}, done_at, 20001);
        check({tag, "_cs_mosi_high"}, {31'd0, pins_bad}, 0);
        check({tag, "_ready_low"}, {31'd0, rdy_bad}, 0);
        check({tag, "_no_rx_valid"}, {31'd0, rx_seen}, 0);
        check({tag, "_sclk_rises"}, rise_total - rise_base, 80);
        check({tag, "_sclk_span"}, last_rise_cyc - first_rise_cyc, 79 * 250);
        check({tag, "_sclk_low_after"}, {31'd0, sclk}, 0);
    endtask
`endif

    // ---------------- vector table ----------------
    typedef struct {
        logic       fast;
        logic [7:0] tx;
        logic [7:0] miso;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
        int         exp_lat;
        int         exp_span;   // cycles from first to eighth SCLK rise
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   lat;
        logic f1;
        logic r1;
        bit   rx_seen;

        vecs[0] = '{1'b0, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 2001, 1750};
        vecs[1] = '{1'b1, 8'h81, 8'h7E, 8'h7E, 8'h81,   33,   28};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00,   33,   28};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF,   33,   28};
        vecs[4] = '{1'b0, 8'h5A, 8'hC3, 8'hC3, 8'h5A, 2001, 1750};

        rst_n          = 1'b0;
        fast           = 1'b0;
        cs_req         = 1'b0;
        bus.i_tx_valid = 1'b0;
        bus.i_tx_data  = 8'h00;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_sclk",      {31'd0, sclk}, 0);
        check("rst_mosi",      {31'd0, mosi}, 1);
        check("rst_cs_n",      {31'd0, cs_n}, 1);
        check("rst_tx_ready",  {31'd0, bus.o_tx_ready}, 0);
        check("rst_rx_valid",  {31'd0, bus.o_rx_valid}, 0);
        check("rst_rx_data",   {24'd0, bus.o_rx_data}, 0);
        check("rst_init_done", {31'd0, init_done}, 0);
        check("rst_fast",      {31'd0, o_fast}, 0);

        // ---- power-up ----
        rst_n = 1'b1;
`ifdef SD_SEQ_INIT_EN
        init_sequence("init");
`else
        @(negedge clk);
        check("noinit_ready_1cyc", {31'd0, bus.o_tx_ready}, 1);
        check("noinit_done_1cyc",  {31'd0, init_done}, 1);
`endif

        // ---- chip select follows request one cycle later ----
        wait_ready();
        cs_req = 1'b1;
        check("cs_n_before_edge", {31'd0, cs_n}, 1);
        @(negedge clk);
        check("cs_n_after_edge",  {31'd0, cs_n}, 0);

        // ---- table-driven single transfers ----
        for (int i = 0; i < 5; i++) begin
            wait_ready();
            start_xfer(vecs[i].fast, vecs[i].tx, vecs[i].miso);
            wait_rx(1'b0, 0, lat, f1, r1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_rx_data", i), {24'd0, bus.o_rx_data}, {24'd0, vecs[i].exp_rx});
            check($sformatf("v%0d_mosi_bits", i), {24'd0, mosi_sh}, {24'd0, vecs[i].exp_mosi});
            check($sformatf("v%0d_o_fast", i), {31'd0, f1}, {31'd0, vecs[i].fast});
            check($sformatf("v%0d_ready_low", i), {31'd0, r1}, 0);
            check($sformatf("v%0d_rises", i), rise_total - rise_base, 8);
            check($sformatf("v%0d_sclk_span", i), last_rise_cyc - first_rise_cyc, vecs[i].exp_span);
            check($sformatf("v%0d_end_pins", i), {30'd0, sclk, mosi}, 32'd1);
        end

        // ---- back-to-back fast: 0xFF then 0x00 with valid held ----
        wait_ready();
        start_xfer(1'b1, 8'hFF, 8'h00);
        wait_rx(1'b1, 0, lat, f1, r1);
        check("b2b1_latency", lat, 33);
        check("b2b1_rx_data", {24'd0, bus.o_rx_data}, 32'h00);
        check("b2b1_mosi_bits", {24'd0, mosi_sh}, 32'hFF);
        check("b2b_ready_at_rx", {31'd0, bus.o_tx_ready}, 1);
        start_xfer(1'b1, 8'h00, 8'hA5);  // accepted in this o_rx_valid cycle
        wait_rx(1'b0, 0, lat, f1, r1);
        check("b2b2_accepted_at_rx", {31'd0, r1}, 0);
        check("b2b2_latency", lat, 33);
        check("b2b2_rx_data", {24'd0, bus.o_rx_data}, 32'hA5);
        check("b2b2_mosi_bits", {24'd0, mosi_sh}, 32'h00);
        check("b2b2_sclk_span", last_rise_cyc - first_rise_cyc, 28);

        // ---- speed request and chip select changed mid-SHIFT ----
        wait_ready();
        start_xfer(1'b0, 8'h96, 8'h69);
        wait_rx(1'b0, 500, lat, f1, r1);
        check("tog_slow_latency", lat, 2001);
        check("tog_rx_data", {24'd0, bus.o_rx_data}, 32'h69);
        check("tog_fast_held", {31'd0, o_fast}, 0);
        check("tog_cs_frozen", {31'd0, cs_n}, 0);
        start_xfer(1'b1, 8'h3C, 8'hC3);
        wait_rx(1'b0, 0, lat, f1, r1);
        check("tog_next_fast_at_accept", {31'd0, f1}, 1);
        check("tog_cs_released", {31'd0, cs_n}, 1);
        check("tog_next_latency", lat, 33);
        check("tog_next_rx_data", {24'd0, bus.o_rx_data}, 32'hC3);

        // ---- reset pulsed at SHIFT tick 7 (4th SCLK rise) ----
        wait_ready();
        cs_req = 1'b1;
        @(negedge clk);
        wait_ready();
        start_xfer(1'b0, 8'hF0, 8'h0F);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            bus.i_tx_valid = 1'b0;
            if (rise_total - rise_base >= 4) break;
        end
        check("mid_reached_tick7", rise_total - rise_base, 4);
        check("mid_cs_asserted", {31'd0, cs_n}, 0);
        check("mid_sclk_high", {31'd0, sclk}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_sclk",      {31'd0, sclk}, 0);
        check("mid_rst_cs_n",      {31'd0, cs_n}, 1);
        check("mid_rst_tx_ready",  {31'd0, bus.o_tx_ready}, 0);
        check("mid_rst_mosi",      {31'd0, mosi}, 1);
        check("mid_rst_init_done", {31'd0, init_done}, 0);
        cs_req = 1'b0;
        fast   = 1'b1;   // must be ignored until the next accept
        rst_n  = 1'b1;
`ifdef SD_SEQ_INIT_EN
        init_sequence("reinit");
`else
        @(negedge clk);
        check("mid_ready_1cyc", {31'd0, bus.o_tx_ready}, 1);
        rx_seen = 1'b0;
        repeat (2100) begin
            @(negedge clk);
            if (bus.o_rx_valid) rx_seen = 1'b1;
        end
        check("mid_no_rx_valid", {31'd0, rx_seen}, 0);
        check("mid_fast_still_reset", {31'd0, o_fast}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
